tx_serial_8b10b: RTL and testbench
==================================

TX_SERIAL_8B10B -- requirements
Module: tx_serial_8b10b

Interface
REQ-001 SHALL have parameter TICKS_PER_BIT, default 2: clock cycles per serial bit; legal range >=1.
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 = encoder dataout[0] (bit a) first; 0 = dataout[9] (bit j) first.
REQ-003 SHALL have parameter IDLE_CHAR, default 9'h1BC (K28.5; bit 8 = K flag): character sent when no data is pending.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 en_i  in  1  serializer enable.
REQ-007 data_i  in  9  character; [8] = K flag, [7:0] = byte.
REQ-008 valid_i  in  1  data_i is valid.
REQ-009 ready_o  out  1  holding register empty; a character transfers when valid_i && ready_o.
REQ-010 data_o  out  1  serial line.
REQ-011 sym_o  out  1  one-cycle pulse on the first cycle of each symbol on data_o.
REQ-012 idle_o  out  1  high for the whole of any symbol that is IDLE_CHAR fill.

Function
REQ-013 SHALL implement states OFF and SHIFT.
REQ-014 Load event L = en_i && (state==OFF || (bit_cnt==9 && tick_cnt==TICKS_PER_BIT-1)).
REQ-015 On L: shift register <= encoder output; running disparity <= encoder dispout; bit_cnt, tick_cnt <= 0; state <= SHIFT.
REQ-016 On L, if the holding register is full, the held character is encoded and the holding register empties; otherwise IDLE_CHAR is encoded and idle_o is set for that symbol.
REQ-017 Encoder input uses the current registered running disparity; disparity changes only on L.
REQ-018 In SHIFT, tick_cnt counts 0..TICKS_PER_BIT-1; on wrap, the shift register advances one bit and bit_cnt increments.
REQ-019 Each symbol lasts exactly 10*TICKS_PER_BIT cycles; consecutive symbols have no gap while en_i=1.
REQ-020 At the last tick of a symbol with en_i=0: state <= OFF, no load; data_o=0 while OFF; disparity is retained.
REQ-021 Deasserting en_i mid-symbol SHALL NOT truncate the current symbol.
REQ-022 Holding register is one entry; ready_o = !full. A character accepted in the same cycle as L is not used by that L (no bypass); it goes out in the next symbol.
REQ-023 sym_o is registered and asserted in the cycle after L, coincident with the first bit on data_o.
REQ-024 TICKS_PER_BIT=1: tick counter is one bit wide and held at 0; one bit per cycle.

Reset
REQ-025 While rst_ni=0: state=OFF, shift register=0, running disparity=0 (RD-), counters=0, holding register empty.
REQ-026 Reset outputs: data_o=0, sym_o=0, idle_o=0, ready_o=1.
REQ-027 Reset assertion mid-symbol SHALL force data_o=0 immediately and discard any held character.

Structure
REQ-028 Package tx_serial_pkg SHALL hold K28_5 (9'h1BC), SYM_BITS (10) and the 9-bit character typedef.
REQ-029 SHALL instantiate the existing encode_8b10b as its sole sub-module; all other logic stays in tx_serial_8b10b.

Verification
REQ-030 Reset, en_i=1, valid_i=0: K28.5 symbols alternate, a-first 0011111010 then 1100000101; idle_o=1; sym_o every 20 cycles.
REQ-031 Send 9'h0B5 (D21.5): data_o carries 1010101010; idle_o=0 for that symbol; disparity unchanged.
REQ-032 valid_i held with 9'h001, 9'h002, 9'h003: ready_o low while full; each character is accepted once, in order; three consecutive data symbols, then idle.
REQ-033 en_i dropped at bit 4: symbol completes; data_o=0; re-enable resumes with correct disparity (K28.5 RD+ code if the last symbol left RD+).
REQ-034 rst_ni pulsed low at bit 6 with a character held: data_o=0 at once; held character lost; ready_o=1.
REQ-035 TICKS_PER_BIT=1 and 4 (with LSB_FIRST=0): sym_o period is 10 / 40 cycles; bit order is j first.

Source files
------------

// File: rtl/tx_serial_pkg.sv
// Shared types and constants for the 8b/10b serial transmitter.
package tx_serial_pkg;

    localparam logic [8:0] K28_5    = 9'h1BC;
    localparam int         SYM_BITS = 10;

    // Character: [8] = K flag, [7:0] = byte (HGF EDCBA).
    typedef logic [8:0] char_t;

    typedef enum logic {
        OFF   = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/encode_8b10b.sv
// Combinational 8b/10b encoder; dataout[0] is bit a, dataout[9] is bit j.
module encode_8b10b (
    input  logic [8:0] datain,
    input  logic       dispin,
    output logic [9:0] dataout,
    output logic       dispout
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k;
    logic [5:0] six_n;
    logic [3:0] four_tab;
    logic [3:0] four_base;
    logic [5:0] six;
    logic [3:0] four;
    logic       six_unbal;
    logic       six_alt;
    logic       four_unbal;
    logic       four_alt;
    logic       rd_mid;
    logic       use_a7;
    logic       kflip;

    always_comb begin
        x = datain[4:0];
        y = datain[7:5];
        k = datain[8];

        // 5b/6b codes in RD- form, written abcdei with a as the MSB.
        case (x)
            5'd0:  six_n = 6'b100111;
            5'd1:  six_n = 6'b011101;
            5'd2:  six_n = 6'b101101;
            5'd3:  six_n = 6'b110001;
            5'd4:  six_n = 6'b110101;
            5'd5:  six_n = 6'b101001;
            5'd6:  six_n = 6'b011001;
            5'd7:  six_n = 6'b111000;
            5'd8:  six_n = 6'b111001;
            5'd9:  six_n = 6'b100101;
            5'd10: six_n = 6'b010101;
            5'd11: six_n = 6'b110100;
            5'd12: six_n = 6'b001101;
            5'd13: six_n = 6'b101100;
            5'd14: six_n = 6'b011100;
            5'd15: six_n = 6'b010111;
            5'd16: six_n = 6'b011011;
            5'd17: six_n = 6'b100011;
            5'd18: six_n = 6'b010011;
            5'd19: six_n = 6'b110010;
            5'd20: six_n = 6'b001011;
            5'd21: six_n = 6'b101010;
            5'd22: six_n = 6'b011010;
            5'd23: six_n = 6'b111010;
            5'd24: six_n = 6'b110011;
            5'd25: six_n = 6'b100110;
            5'd26: six_n = 6'b010110;
            5'd27: six_n = 6'b110110;
            5'd28: six_n = k ? 6'b001111 : 6'b001110;
            5'd29: six_n = 6'b101110;
            5'd30: six_n = 6'b011110;
            default: six_n = 6'b101011;
        endcase

        six_unbal = ($countones(six_n) != 3);
        six_alt   = six_unbal || (x == 5'd7);
        six       = (dispin && six_alt) ? ~six_n : six_n;
        rd_mid    = dispin ^ six_unbal;

        // Alternate x.A7 avoids a run of five equal bits across the 6b/4b seam.
        use_a7 = (y == 3'd7) && (k ||
                 (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                 ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));

        case (y)
            3'd0:    four_tab = 4'b1011;
            3'd1:    four_tab = 4'b1001;
            3'd2:    four_tab = 4'b0101;
            3'd3:    four_tab = 4'b1100;
            3'd4:    four_tab = 4'b1101;
            3'd5:    four_tab = 4'b1010;
            3'd6:    four_tab = 4'b0110;
            default: four_tab = use_a7 ? 4'b0111 : 4'b1110;
        endcase

        // Control characters use the complemented form of balanced 3b/4b codes.
        kflip      = k && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6);
        four_base  = four_tab ^ {4{kflip}};
        four_unbal = ($countones(four_tab) != 2);
        four_alt   = four_unbal || (y == 3'd3) || kflip;
        four       = (rd_mid && four_alt) ? ~four_base : four_base;
        dispout    = rd_mid ^ four_unbal;

        for (int i = 0; i < 6; i++) begin
            dataout[i] = six[5 - i];
        end
        for (int i = 0; i < 4; i++) begin
            dataout[6 + i] = four[3 - i];
        end
    end

endmodule

// File: rtl/tx_serial_8b10b.sv
// 8b/10b serial transmitter: one-entry holding register, encoder, and bit shifter
// that fills with IDLE_CHAR whenever no character is pending.
module tx_serial_8b10b
    import tx_serial_pkg::*;
#(
    parameter int         TICKS_PER_BIT = 2,
    parameter int         LSB_FIRST     = 1,
    parameter logic [8:0] IDLE_CHAR     = K28_5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [8:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       data_o,
    output logic       sym_o,
    output logic       idle_o
);

    localparam int             TW        = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [3:0]     BIT_LAST  = 4'(SYM_BITS - 1);

    state_e         state_q;
    logic [9:0]     shift_q;
    logic           rd_q;
    logic [3:0]     bit_cnt_q;
    logic [TW-1:0]  tick_cnt_q;
    char_t          hold_q;
    logic           full_q;
    logic           sym_q;
    logic           idle_q;

    logic           tick_last;
    logic           sym_end;
    logic           load;
    logic           accept;
    char_t          enc_char;
    logic [9:0]     enc_code;
    logic           enc_rd;
    logic [9:0]     shift_d;
    logic           line_bit;

    assign tick_last = (tick_cnt_q == TICK_LAST);
    assign sym_end   = (state_q == SHIFT) && (bit_cnt_q == BIT_LAST) && tick_last;
    assign load      = en_i && ((state_q == OFF) || sym_end);
    assign accept    = valid_i && !full_q;
    assign enc_char  = full_q ? hold_q : IDLE_CHAR;
    assign shift_d   = (LSB_FIRST != 0) ? {1'b0, shift_q[9:1]} : {shift_q[8:0], 1'b0};
    assign line_bit  = (LSB_FIRST != 0) ? shift_q[0] : shift_q[9];

    encode_8b10b u_enc (
        .datain  (enc_char),
        .dispin  (rd_q),
        .dataout (enc_code),
        .dispout (enc_rd)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= OFF;
            shift_q    <= '0;
            rd_q       <= 1'b0;
            bit_cnt_q  <= '0;
            tick_cnt_q <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            sym_q      <= 1'b0;
            idle_q     <= 1'b0;
        end else begin
            sym_q <= load;

            // A load only ever drains a character that was held before this edge.
            if (accept) begin
                hold_q <= data_i;
                full_q <= 1'b1;
            end else if (load && full_q) begin
                full_q <= 1'b0;
            end

            if (load) begin
                state_q    <= SHIFT;
                shift_q    <= enc_code;
                rd_q       <= enc_rd;
                bit_cnt_q  <= '0;
                tick_cnt_q <= '0;
                idle_q     <= !full_q;
            end else if (state_q == SHIFT) begin
                if (sym_end) begin
                    state_q    <= OFF;
                    shift_q    <= '0;
                    bit_cnt_q  <= '0;
                    tick_cnt_q <= '0;
                    idle_q     <= 1'b0;
                end else if (tick_last) begin
                    shift_q    <= shift_d;
                    bit_cnt_q  <= bit_cnt_q + 4'd1;
                    tick_cnt_q <= '0;
                end else begin
                    tick_cnt_q <= tick_cnt_q + 1'b1;
                end
            end
        end
    end

    assign ready_o = !full_q;
    assign data_o  = (state_q == SHIFT) && line_bit;
    assign sym_o   = sym_q;
    assign idle_o  = idle_q;

endmodule

// File: tb/tb_tx_serial_8b10b.sv
// Directed self-checking bench for tx_serial_8b10b: idle fill, data, flow control,
// enable gating, mid-symbol reset, and the 1- and 4-tick j-first variants.
module tb_tx_serial_8b10b;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, valid;
    logic [8:0] data;
    logic       ready, dout, sym, idle;

    logic       rst2_n, en2, valid2;
    logic [8:0] data2;
    logic       ready1, dout1, sym1, idle1;
    logic       ready4, dout4, sym4, idle4;

    int tests  = 0;
    int failed = 0;
    int per;
    int n;

    typedef struct {
        logic [9:0] bits;
        logic       idle;
        int         period;
    } sym_rec_t;

    sym_rec_t mon_q[$];

    localparam logic [9:0] K285_N  = 10'b0011111010;
    localparam logic [9:0] K285_P  = 10'b1100000101;
    localparam logic [9:0] K285_NR = 10'b0101111100;
    localparam logic [9:0] K285_PR = 10'b1010000011;

    logic       d1a [80];
    logic       s1a [80];
    logic       d4a [80];
    logic       s4a [80];
    logic [9:0] b1a, b1b, b4a, b4b;

    tx_serial_8b10b #(.TICKS_PER_BIT(2), .LSB_FIRST(1), .IDLE_CHAR(9'h1BC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .data_i(data), .valid_i(valid),
        .ready_o(ready), .data_o(dout), .sym_o(sym), .idle_o(idle)
    );

    tx_serial_8b10b #(.TICKS_PER_BIT(1), .LSB_FIRST(0), .IDLE_CHAR(9'h1BC)) dut1 (
        .clk_i(clk), .rst_ni(rst2_n), .en_i(en2), .data_i(data2), .valid_i(valid2),
        .ready_o(ready1), .data_o(dout1), .sym_o(sym1), .idle_o(idle1)
    );

    tx_serial_8b10b #(.TICKS_PER_BIT(4), .LSB_FIRST(0), .IDLE_CHAR(9'h1BC)) dut4 (
        .clk_i(clk), .rst_ni(rst2_n), .en_i(en2), .data_i(data2), .valid_i(valid2),
        .ready_o(ready4), .data_o(dout4), .sym_o(sym4), .idle_o(idle4)
    );

    // Symbol monitor for the main instance (2 cycles per bit, first bit lands in MSB).
    initial begin
        int         mon_cyc, mon_last, mon_tick, mon_cnt;
        logic       mon_active, mon_idle;
        logic [9:0] mon_sr;
        sym_rec_t   rec;
        mon_cyc = 0; mon_last = 0; mon_tick = 0; mon_cnt = 0;
        mon_active = 1'b0; mon_idle = 1'b0; mon_sr = '0;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (rst_n !== 1'b1) begin
                mon_active = 1'b0;
            end else if (sym === 1'b1) begin
                rec.period = mon_cyc - mon_last;
                mon_last   = mon_cyc;
                mon_sr     = {9'b0, dout};
                mon_idle   = idle;
                mon_cnt    = 1;
                mon_tick   = 0;
                mon_active = 1'b1;
            end else if (mon_active) begin
                mon_idle = mon_idle & idle;
                mon_tick++;
                if (mon_tick == 2) begin
                    mon_tick = 0;
                    mon_sr   = {mon_sr[8:0], dout};
                    mon_cnt++;
                    if (mon_cnt == 10) begin
                        rec.bits = mon_sr;
                        rec.idle = mon_idle;
                        mon_q.push_back(rec);
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_sym(input string tag, input logic [9:0] eb, input logic ei,
                             output int period);
        sym_rec_t s;
        int w = 0;
        while (mon_q.size() == 0 && w < 200) begin
            tick();
            w++;
        end
        chk({tag, "_arrived"}, 32'(mon_q.size() != 0), 32'd1);
        if (mon_q.size() != 0) begin
            s = mon_q.pop_front();
        end else begin
            s.bits = '0; s.idle = 1'b0; s.period = 0;
        end
        chk({tag, "_bits"}, 32'(s.bits), 32'(eb));
        chk({tag, "_idle"}, 32'(s.idle), 32'(ei));
        period = s.period;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; valid = 1'b0; data = '0;
        rst2_n = 1'b0; en2 = 1'b0; valid2 = 1'b0; data2 = '0;
        repeat (3) tick();

        chk("rst_data",  32'(dout),  32'd0);
        chk("rst_sym",   32'(sym),   32'd0);
        chk("rst_idle",  32'(idle),  32'd0);
        chk("rst_ready", 32'(ready), 32'd1);

        // Idle fill alternates K28.5 RD- / RD+.
        rst_n = 1'b1; en = 1'b1;
        check_sym("k1", K285_N, 1'b1, per);
        check_sym("k2", K285_P, 1'b1, per);
        chk("k2_period", 32'(per), 32'd20);

        // D21.5 is neutral: the following fill keeps RD- coding.
        data = 9'h0B5; valid = 1'b1;
        tick();
        chk("d21_ready_low", 32'(ready), 32'd0);
        valid = 1'b0;
        check_sym("d21_5", 10'b1010101010, 1'b0, per);
        chk("d21_period", 32'(per), 32'd20);
        check_sym("rd_kept", K285_N, 1'b1, per);

        // Back-to-back characters with valid held; starts at RD+.
        for (int i = 0; i < 3; i++) begin
            data = 9'(i + 1); valid = 1'b1; n = 0;
            while (!ready && n < 100) begin
                tick();
                n++;
            end
            chk("bk_ready_seen", 32'(ready), 32'd1);
            tick();
            chk("bk_ready_low", 32'(ready), 32'd0);
        end
        valid = 1'b0;
        check_sym("d1_0", 10'b1000101011, 1'b0, per);
        check_sym("d2_0", 10'b0100101011, 1'b0, per);
        chk("d2_period", 32'(per), 32'd20);
        check_sym("d3_0", 10'b1100010100, 1'b0, per);
        chk("d3_period", 32'(per), 32'd20);
        check_sym("after_bk", K285_N, 1'b1, per);

        // Enable dropped at bit 4 of a symbol that leaves RD+.
        check_sym("k9", K285_P, 1'b1, per);
        n = 0;
        while (!sym && n < 50) begin
            tick();
            n++;
        end
        chk("k10_start", 32'(sym), 32'd1);
        repeat (8) tick();
        en = 1'b0;
        check_sym("k10_full", K285_N, 1'b1, per);
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            chk("off_data", 32'(dout), 32'd0);
            chk("off_sym",  32'(sym),  32'd0);
            tick();
        end
        en = 1'b1;
        check_sym("resume_rdp", K285_P, 1'b1, per);

        // Reset at bit 6 while a character is held.
        n = 0;
        while (!sym && n < 50) begin
            tick();
            n++;
        end
        chk("k12_start", 32'(sym), 32'd1);
        data = 9'h0AA; valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("hold_full", 32'(ready), 32'd0);
        repeat (11) tick();
        chk("pre_rst_data", 32'(dout), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_data",  32'(dout),  32'd0);
        chk("rst_async_ready", 32'(ready), 32'd1);
        chk("rst_async_sym",   32'(sym),   32'd0);
        chk("rst_async_idle",  32'(idle),  32'd0);
        repeat (2) tick();
        mon_q.delete();
        rst_n = 1'b1;
        check_sym("post_rst_k1", K285_N, 1'b1, per);
        check_sym("post_rst_k2", K285_P, 1'b1, per);

        // j-first variants with 1 and 4 ticks per bit.
        chk("var_rst_ready1", 32'(ready1), 32'd1);
        chk("var_rst_data4",  32'(dout4),  32'd0);
        rst2_n = 1'b1; en2 = 1'b1;
        n = 0;
        while (!sym1 && n < 50) begin
            tick();
            n++;
        end
        chk("u1_sym_start", 32'(sym1), 32'd1);
        chk("u4_sym_start", 32'(sym4), 32'd1);
        for (int c = 0; c < 80; c++) begin
            d1a[c] = dout1; s1a[c] = sym1;
            d4a[c] = dout4; s4a[c] = sym4;
            tick();
        end
        b1a = '0; b1b = '0; b4a = '0; b4b = '0;
        for (int k = 0; k < 10; k++) begin
            b1a = {b1a[8:0], d1a[k]};
            b1b = {b1b[8:0], d1a[10 + k]};
            b4a = {b4a[8:0], d4a[4 * k]};
            b4b = {b4b[8:0], d4a[40 + 4 * k]};
        end
        chk("u1_sym0_bits", 32'(b1a), 32'(K285_NR));
        chk("u1_sym1_bits", 32'(b1b), 32'(K285_PR));
        chk("u4_sym0_bits", 32'(b4a), 32'(K285_NR));
        chk("u4_sym1_bits", 32'(b4b), 32'(K285_PR));
        chk("u1_sym_at10",  32'(s1a[10]), 32'd1);
        chk("u1_sym_at5",   32'(s1a[5]),  32'd0);
        chk("u4_sym_at40",  32'(s4a[40]), 32'd1);
        chk("u4_sym_at20",  32'(s4a[20]), 32'd0);
        chk("u4_sym_at39",  32'(s4a[39]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
